// File: rtl/rangefinder_pkg.sv
// Shared types and default sizing for the rangefinder datapath
// and its byte-stream framer.
package rangefinder_pkg;

    localparam int WIDTH_DEF     = 16;
    localparam int MAX_WORDS_DEF = 255;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        FIN_PEND,
        ERROR
    } state_e;

endpackage

// File: rtl/rangefinder_framer_if.sv
// Host-side framed byte stream: data byte plus valid and
// start/end-of-frame qualifiers.
interface rangefinder_framer_if;

    logic [7:0] byte_in;
    logic       byte_valid;
    logic       sof;
    logic       eof;

    modport master (output byte_in, byte_valid, sof, eof);
    modport slave  (input  byte_in, byte_valid, sof, eof);

endinterface

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer. word_o already contains the
// byte being strobed, so word_done_o and word_o are valid together.
module byte_packer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             strobe_i,
    input  logic             clear_i,
    input  logic [7:0]       byte_i,
    output logic             word_done_o,
    output logic [WIDTH-1:0] word_o
);

    localparam int BYTES = WIDTH / 8;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [IW-1:0]    idx_q, idx_d, cur;
    logic [WIDTH-1:0] sreg_q, sreg_d;

    // clear_i restarts the index so a start-of-frame byte lands in lane 0
    always_comb begin
        cur         = clear_i ? '0 : idx_q;
        idx_d       = idx_q;
        sreg_d      = sreg_q;
        word_done_o = 1'b0;
        if (strobe_i) begin
            sreg_d[8*int'(cur) +: 8] = byte_i;
            word_done_o = (cur == IW'(BYTES - 1));
            idx_d = word_done_o ? '0 : cur + 1'b1;
        end
    end

    assign word_o = sreg_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            sreg_q <= '0;
        end else begin
            idx_q  <= idx_d;
            sreg_q <= sreg_d;
        end
    end

endmodule

// File: rtl/rangefinder_framer.sv
// Turns sof/eof-framed host bytes into go / samples / finish for the
// rangefinder, trapping protocol violations in a local ERROR state.
module rangefinder_framer
    import rangefinder_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int CW        = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    rangefinder_framer_if.slave  host,
    output logic [WIDTH-1:0]     data_out,
    output logic                 go,
    output logic                 finish,
    output logic [CW-1:0]        word_count,
    output logic                 frame_error
);

    state_e           state_q;
    logic             first_q;
    logic [WIDTH-1:0] data_q;
    logic             go_q, fin_q, err_q;
    logic [CW-1:0]    cnt_q;

    logic             strobe, clear, done;
    logic [WIDTH-1:0] word;

    assign strobe = host.byte_valid && ((state_q == FRAME) || host.sof);
    assign clear  = (state_q != FRAME);

    byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .strobe_i   (strobe),
        .clear_i    (clear),
        .byte_i     (host.byte_in),
        .word_done_o(done),
        .word_o     (word)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            data_q  <= '0;
            go_q    <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            go_q  <= 1'b0;
            fin_q <= 1'b0;
            unique case (state_q)
                IDLE, ERROR: begin
                    if (host.byte_valid && host.sof) begin
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        first_q <= 1'b1;
                        state_q <= FRAME;
                        if (done) begin
                            data_q  <= word;
                            cnt_q   <= CW'(1);
                            go_q    <= 1'b1;
                            first_q <= 1'b0;
                            if (host.eof) state_q <= FIN_PEND;
                        end else if (host.eof) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end else if (host.byte_valid && state_q == IDLE) begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                    end
                end
                FRAME: begin
                    if (host.byte_valid) begin
                        if (host.sof) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else if (done) begin
                            // overflow drops the sample and keeps the count
                            if (cnt_q == CW'(MAX_WORDS)) begin
                                state_q <= ERROR;
                                err_q   <= 1'b1;
                            end else begin
                                data_q  <= word;
                                cnt_q   <= cnt_q + CW'(1);
                                first_q <= 1'b0;
                                if (first_q) begin
                                    go_q <= 1'b1;
                                    if (host.eof) state_q <= FIN_PEND;
                                end else if (host.eof) begin
                                    fin_q   <= 1'b1;
                                    state_q <= IDLE;
                                end
                            end
                        end else if (host.eof) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                FIN_PEND: begin
                    if (host.byte_valid) begin
                        state_q <= ERROR;
                        err_q   <= 1'b1;
                    end else begin
                        fin_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign data_out    = data_q;
    assign go          = go_q;
    assign finish      = fin_q;
    assign word_count  = cnt_q;
    assign frame_error = err_q;

endmodule

// File: tb/tb_rangefinder_framer.sv
// Scoreboard bench for rangefinder_framer: expected sample events are
// queued at drive time and matched as go/finish/data changes appear.
module tb_rangefinder_framer;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    rangefinder_framer_if hb ();
    rangefinder_framer_if hb3 ();

    logic [15:0] dout, dout3;
    logic        go, fin, fe, go3, fin3, fe3;
    logic [7:0]  wc, wc3;

    rangefinder_framer #(.WIDTH(16), .MAX_WORDS(255), .CW(8)) dut (
        .clock(clock), .reset_n(reset_n), .host(hb.slave),
        .data_out(dout), .go(go), .finish(fin),
        .word_count(wc), .frame_error(fe)
    );

    rangefinder_framer #(.WIDTH(16), .MAX_WORDS(3), .CW(8)) dut3 (
        .clock(clock), .reset_n(reset_n), .host(hb3.slave),
        .data_out(dout3), .go(go3), .finish(fin3),
        .word_count(wc3), .frame_error(fe3)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        g;
        logic        f;
    } ev_t;

    ev_t         q[$];
    ev_t         exp_ev;
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [15:0] prev;

    // an output event is any go/finish pulse or a change of data_out
    always @(negedge clock) begin
        if (!reset_n) begin
            prev = dout;
        end else if (go || fin || dout !== prev) begin
            total_cnt++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_event got d=%h go=%b fin=%b", dout, go, fin);
            end else begin
                exp_ev = q.pop_front();
                if ({dout, go, fin} !== exp_ev)
                    $display("FAIL sample_event got d=%h go=%b fin=%b want d=%h go=%b fin=%b",
                             dout, go, fin, exp_ev.d, exp_ev.g, exp_ev.f);
                else
                    pass_cnt++;
            end
            prev = dout;
        end
    end

    task automatic push(input logic [15:0] d, input logic g, input logic f);
        ev_t e;
        e.d = d; e.g = g; e.f = f;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input logic s = 1'b0, input logic e = 1'b0);
        @(negedge clock);
        hb.byte_in = b; hb.byte_valid = 1'b1; hb.sof = s; hb.eof = e;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            hb.byte_valid = 1'b0; hb.sof = 1'b0; hb.eof = 1'b0;
        end
    endtask

    task automatic send3(input logic [7:0] b, input logic s = 1'b0, input logic e = 1'b0);
        @(negedge clock);
        hb3.byte_in = b; hb3.byte_valid = 1'b1; hb3.sof = s; hb3.eof = e;
    endtask

    task automatic idle3();
        @(negedge clock);
        hb3.byte_valid = 1'b0; hb3.sof = 1'b0; hb3.eof = 1'b0;
    endtask

    task automatic drain(input string name);
        idle(3);
        total_cnt++;
        if (q.size() !== 0) $display("FAIL %s_drain got %0d pending want 0", name, q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        total_cnt++;
        if ({dout, go, fin, wc, fe} !== 27'd0)
            $display("FAIL reset_outputs got d=%h go=%b fin=%b wc=%0d fe=%b want 0",
                     dout, go, fin, wc, fe);
        else pass_cnt++;
        total_cnt++;
        if ({dout3, go3, fin3, wc3, fe3} !== 27'd0)
            $display("FAIL reset_outputs3 got d=%h wc=%0d fe=%b want 0", dout3, wc3, fe3);
        else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_three_sample();
        send(8'h34, 1'b1); send(8'h12); push(16'h1234, 1'b1, 1'b0);
        send(8'h78);       send(8'h56); push(16'h5678, 1'b0, 1'b0);
        send(8'hBC);       send(8'h9A, 1'b0, 1'b1); push(16'h9ABC, 1'b0, 1'b1);
        drain("three");
        total_cnt++;
        if (wc !== 8'd3) $display("FAIL three_wc got %0d want 3", wc);
        else pass_cnt++;
        total_cnt++;
        if (fe !== 1'b0) $display("FAIL three_fe got %b want 0", fe);
        else pass_cnt++;
    endtask

    task automatic test_single_sample();
        send(8'h01, 1'b1); send(8'h00, 1'b0, 1'b1);
        push(16'h0001, 1'b1, 1'b0);
        push(16'h0001, 1'b0, 1'b1);
        drain("single");
        total_cnt++;
        if (wc !== 8'd1) $display("FAIL single_wc got %0d want 1", wc);
        else pass_cnt++;
    endtask

    task automatic test_partial_eof();
        send(8'hAA, 1'b1); send(8'hBB); push(16'hBBAA, 1'b1, 1'b0);
        send(8'hCC, 1'b0, 1'b1);
        idle(1);
        total_cnt++;
        if ({fe, fin, dout} !== {1'b1, 1'b0, 16'hBBAA})
            $display("FAIL partial_err got fe=%b fin=%b d=%h want 1 0 bbaa", fe, fin, dout);
        else pass_cnt++;
        send(8'h11, 1'b1);
        idle(1);
        total_cnt++;
        if (fe !== 1'b0) $display("FAIL partial_recover_fe got %b want 0", fe);
        else pass_cnt++;
        send(8'h22, 1'b0, 1'b1);
        push(16'h2211, 1'b1, 1'b0);
        push(16'h2211, 1'b0, 1'b1);
        drain("partial");
    endtask

    task automatic test_nested_stray();
        send(8'h55);
        idle(1);
        total_cnt++;
        if (fe !== 1'b1) $display("FAIL stray_fe got %b want 1", fe);
        else pass_cnt++;
        send(8'h01, 1'b1);
        idle(1);
        total_cnt++;
        if (fe !== 1'b0) $display("FAIL nested_start_fe got %b want 0", fe);
        else pass_cnt++;
        send(8'h02, 1'b1);
        idle(1);
        total_cnt++;
        if ({fe, wc} !== {1'b1, 8'd0})
            $display("FAIL nested_err got fe=%b wc=%0d want 1 0", fe, wc);
        else pass_cnt++;
        drain("nested");
    endtask

    task automatic test_gaps_reset();
        send(8'h0D, 1'b1);
        idle(5);
        send(8'h0C); push(16'h0C0D, 1'b1, 1'b0);
        send(8'hEE);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({dout, go, fin, wc, fe} !== 27'd0)
            $display("FAIL async_reset got d=%h go=%b fin=%b wc=%0d fe=%b want 0",
                     dout, go, fin, wc, fe);
        else pass_cnt++;
        hb.byte_valid = 1'b0; hb.sof = 1'b0; hb.eof = 1'b0;
        @(negedge clock);
        #1 reset_n = 1'b1;
        idle(1);
        send(8'h21, 1'b1); send(8'h43); push(16'h4321, 1'b1, 1'b0);
        send(8'h65);       send(8'h87, 1'b0, 1'b1); push(16'h8765, 1'b0, 1'b1);
        drain("gaps");
        total_cnt++;
        if (wc !== 8'd2) $display("FAIL gaps_wc got %0d want 2", wc);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        for (int i = 1; i <= 3; i++) begin
            b = 8'(i);
            send3(b, i == 1); send3(8'h00);
            idle3();
            total_cnt++;
            if ({dout3, go3, fin3, wc3} !== {8'h00, b, i == 1, 1'b0, b})
                $display("FAIL ovf_sample%0d got d=%h go=%b fin=%b wc=%0d", i, dout3, go3, fin3, wc3);
            else pass_cnt++;
        end
        send3(8'h04); send3(8'h00, 1'b0, 1'b1);
        idle3();
        total_cnt++;
        if ({fe3, fin3, go3, wc3, dout3} !== {1'b1, 1'b0, 1'b0, 8'd3, 16'h0003})
            $display("FAIL ovf_err got fe=%b fin=%b go=%b wc=%0d d=%h want 1 0 0 3 0003",
                     fe3, fin3, go3, wc3, dout3);
        else pass_cnt++;
    endtask

    initial begin
        hb.byte_in = '0; hb.byte_valid = 1'b0; hb.sof = 1'b0; hb.eof = 1'b0;
        hb3.byte_in = '0; hb3.byte_valid = 1'b0; hb3.sof = 1'b0; hb3.eof = 1'b0;
        test_reset();
        test_three_sample();
        test_single_sample();
        test_partial_eof();
        test_nested_stray();
        test_gaps_reset();
        test_overflow();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
